branch_resolve: RTL and testbench



---
 rtl/core_pkg.sv | 27 ++
 rtl/branch_resolve.sv | 156 +++++++++++++++
 tb/tb_branch_resolve.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the RV32I execute stage: control-op codes, branch
// funct3 values and the branch-resolve FSM state type.
package core_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_BR   = 2'b01;
    localparam logic [1:0] OP_JAL  = 2'b10;
    localparam logic [1:0] OP_JALR = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN,
        ST_SQUASH
    } resolveState_t;

    // funct3 010/011 carry no branch condition in RV32I
    function automatic logic isIllegalF3(input logic [2:0] f3);
        return (f3[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution: condition and target evaluation, a
// one-entry registered output stage, fetch redirect/trap pulses and wrong-path squash.
module branch_resolve
    import core_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int KILL_SLOTS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_op,
    output logic [XLEN-1:0] cmp_a,
    output logic [XLEN-1:0] cmp_b,
    output logic            cmp_umod,
    input  logic            cmp_less,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_link,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_tval
);

    localparam logic [2:0]      KILL_LOAD = 3'(KILL_SLOTS);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    resolveState_t state, nextState;
    logic [2:0] killCnt, nextKillCnt;

    logic            isEqual;
    logic            condMet;
    logic            illegalBr;
    logic            taken;
    logic            misaligned;
    logic            doRedirect;
    logic            doTrap;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] trapValue;
    logic [XLEN-1:0] linkPc;
    logic            accept;

    assign cmp_a    = in_rs1;
    assign cmp_b    = in_rs2;
    assign cmp_umod = in_funct3[1];

    always_comb begin
        isEqual    = (in_rs1 == in_rs2);
        condMet    = 1'b0;
        illegalBr  = (in_op == OP_BR) && isIllegalF3(in_funct3);
        target     = in_pc + in_imm;
        taken      = 1'b0;
        linkPc     = in_pc + XLEN'(4);

        case (in_funct3)
            F3_BEQ:           condMet = isEqual;
            F3_BNE:           condMet = !isEqual;
            F3_BLT, F3_BLTU:  condMet = cmp_less;
            F3_BGE, F3_BGEU:  condMet = !cmp_less;
            default:          condMet = 1'b0;
        endcase

        case (in_op)
            OP_BR:   taken = condMet && !illegalBr;
            OP_JAL:  taken = 1'b1;
            OP_JALR: begin
                taken  = 1'b1;
                target = (in_rs1 + in_imm) & ALIGN_MASK;
            end
            default: taken = 1'b0;
        endcase

        misaligned = taken && target[1];
        doRedirect = taken && !target[1];
        doTrap     = illegalBr || misaligned;
        trapValue  = illegalBr ? in_pc : target;
    end

    // In SQUASH every beat is swallowed, so the block always looks ready
    always_comb begin
        nextState   = state;
        nextKillCnt = killCnt;
        in_ready    = 1'b1;
        accept      = 1'b0;

        case (state)
            ST_RUN: begin
                in_ready = !out_valid || out_ready;
                accept   = in_valid && in_ready;
                if (accept && (doRedirect || doTrap)) begin
                    nextState   = ST_SQUASH;
                    nextKillCnt = KILL_LOAD;
                end
            end
            ST_SQUASH: begin
                in_ready    = 1'b1;
                nextKillCnt = killCnt - 3'd1;
                if (killCnt <= 3'd1) begin
                    nextState = ST_RUN;
                end
            end
            default: begin
                nextState   = ST_RUN;
                nextKillCnt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            killCnt <= 3'd0;
        end else begin
            state   <= nextState;
            killCnt <= nextKillCnt;
        end
    end

    // Pulses are raised only by the capturing edge, so a stalled result never re-fires them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_link       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            trap_valid     <= 1'b0;
            trap_tval      <= '0;
        end else begin
            redirect_valid <= accept && doRedirect;
            trap_valid     <= accept && doTrap;
            if (accept) begin
                out_valid <= 1'b1;
                out_taken <= taken;
                out_link  <= linkPc;
                if (doRedirect) begin
                    redirect_pc <= target;
                end
                if (doTrap) begin
                    trap_tval <= trapValue;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve with hand-computed expectations.
module tb_branch_resolve;
    import core_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [2:0]  in_funct3;
    logic [1:0]  in_op;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic        cmp_umod;
    logic        cmp_less;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_link;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_tval;

    int checks;
    int failures;

    branch_resolve #(.XLEN(32), .KILL_SLOTS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_op(in_op),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_umod(cmp_umod), .cmp_less(cmp_less),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken), .out_link(out_link),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_tval(trap_tval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic less);
        in_valid  = 1'b1;
        in_op     = op;
        in_funct3 = f3;
        in_pc     = pc;
        in_imm    = imm;
        in_rs1    = rs1;
        in_rs2    = rs2;
        cmp_less  = less;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_op    = OP_NONE;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if (out_taken !== 1'b0) begin failures++; $display("FAIL reset_out_taken got=%0h exp=0", out_taken); end
        checks++; if (out_link !== 32'h0) begin failures++; $display("FAIL reset_out_link got=%0h exp=0", out_link); end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect_valid got=%0h exp=0", redirect_valid); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect_pc got=%0h exp=0", redirect_pc); end
        checks++; if (trap_valid !== 1'b0) begin failures++; $display("FAIL reset_trap_valid got=%0h exp=0", trap_valid); end
        checks++; if (trap_tval !== 32'h0) begin failures++; $display("FAIL reset_trap_tval got=%0h exp=0", trap_tval); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_blt_taken;
        out_ready = 1'b1;
        drive(OP_BR, F3_BLT, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b1);
        #1;
        checks++; if (cmp_umod !== 1'b0) begin failures++; $display("FAIL blt_cmp_umod got=%0h exp=0", cmp_umod); end
        checks++; if (cmp_a !== 32'hFFFF_FFFF) begin failures++; $display("FAIL blt_cmp_a got=%0h exp=ffffffff", cmp_a); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL blt_in_ready got=%0h exp=1", in_ready); end
        tick();
        checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL blt_redirect_valid got=%0h exp=1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h120) begin failures++; $display("FAIL blt_redirect_pc got=%0h exp=120", redirect_pc); end
        checks++; if (out_taken !== 1'b1) begin failures++; $display("FAIL blt_out_taken got=%0h exp=1", out_taken); end
        checks++; if (out_link !== 32'h104) begin failures++; $display("FAIL blt_out_link got=%0h exp=104", out_link); end
        // wrong-path JAL held on the input through the squash window
        drive(OP_JAL, F3_BEQ, 32'h200, 32'h40, 32'h0, 32'h0, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL blt_squash_ready1 got=%0h exp=1", in_ready); end
        tick();
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL blt_pulse_once got=%0h exp=0", redirect_valid); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL blt_squash_discard1 got=%0h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL blt_squash_ready2 got=%0h exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL blt_squash_discard2 got=%0h exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL blt_post_squash_accept got=%0h exp=1", out_valid); end
        checks++; if (out_link !== 32'h204) begin failures++; $display("FAIL blt_post_squash_link got=%0h exp=204", out_link); end
        checks++; if (redirect_pc !== 32'h240) begin failures++; $display("FAIL blt_post_squash_target got=%0h exp=240", redirect_pc); end
        idle(4);
    endtask

    task automatic test_bltu_not_taken;
        out_ready = 1'b1;
        drive(OP_BR, F3_BLTU, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b0);
        #1;
        checks++; if (cmp_umod !== 1'b1) begin failures++; $display("FAIL bltu_cmp_umod got=%0h exp=1", cmp_umod); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bltu_out_valid got=%0h exp=1", out_valid); end
        checks++; if (out_taken !== 1'b0) begin failures++; $display("FAIL bltu_out_taken got=%0h exp=0", out_taken); end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL bltu_redirect got=%0h exp=0", redirect_valid); end
        checks++; if (trap_valid !== 1'b0) begin failures++; $display("FAIL bltu_trap got=%0h exp=0", trap_valid); end
        drive(OP_NONE, F3_BEQ, 32'h300, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        checks++; if (out_link !== 32'h304) begin failures++; $display("FAIL bltu_next_accept_link got=%0h exp=304", out_link); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bltu_next_accept_valid got=%0h exp=1", out_valid); end
        idle(2);
    endtask

    task automatic test_jalr_misaligned;
        out_ready = 1'b1;
        drive(OP_JALR, F3_BEQ, 32'h400, 32'h2, 32'h1001, 32'h0, 1'b0);
        tick();
        checks++; if (trap_valid !== 1'b1) begin failures++; $display("FAIL jalr_trap_valid got=%0h exp=1", trap_valid); end
        checks++; if (trap_tval !== 32'h1002) begin failures++; $display("FAIL jalr_trap_tval got=%0h exp=1002", trap_tval); end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL jalr_no_redirect got=%0h exp=0", redirect_valid); end
        checks++; if (out_taken !== 1'b1) begin failures++; $display("FAIL jalr_out_taken got=%0h exp=1", out_taken); end
        checks++; if (out_link !== 32'h404) begin failures++; $display("FAIL jalr_out_link got=%0h exp=404", out_link); end
        drive(OP_NONE, F3_BEQ, 32'h500, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL jalr_squash got=%0h exp=0", out_valid); end
        checks++; if (trap_valid !== 1'b0) begin failures++; $display("FAIL jalr_trap_once got=%0h exp=0", trap_valid); end
        idle(4);
    endtask

    task automatic test_beq_stall;
        out_ready = 1'b0;
        drive(OP_BR, F3_BEQ, 32'h600, 32'h10, 32'h5, 32'h5, 1'b0);
        tick();
        checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL beq_redirect_valid got=%0h exp=1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h610) begin failures++; $display("FAIL beq_redirect_pc got=%0h exp=610", redirect_pc); end
        idle(1);
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL beq_single_pulse got=%0h exp=0", redirect_valid); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL beq_hold1 got=%0h exp=1", out_valid); end
        idle(1);
        drive(OP_NONE, F3_BEQ, 32'h700, 32'h0, 32'h0, 32'h0, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL beq_stall_in_ready got=%0h exp=0", in_ready); end
        tick();
        checks++; if (out_link !== 32'h604) begin failures++; $display("FAIL beq_hold_link got=%0h exp=604", out_link); end
        checks++; if (out_taken !== 1'b1) begin failures++; $display("FAIL beq_hold_taken got=%0h exp=1", out_taken); end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL beq_no_repeat got=%0h exp=0", redirect_valid); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL beq_drain_ready got=%0h exp=1", in_ready); end
        tick();
        checks++; if (out_link !== 32'h704) begin failures++; $display("FAIL beq_replace_link got=%0h exp=704", out_link); end
        checks++; if (out_taken !== 1'b0) begin failures++; $display("FAIL beq_replace_taken got=%0h exp=0", out_taken); end
        idle(1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL beq_drained got=%0h exp=0", out_valid); end
    endtask

    task automatic test_illegal_funct3;
        out_ready = 1'b1;
        drive(OP_BR, 3'b010, 32'h800, 32'h40, 32'h1, 32'h1, 1'b0);
        tick();
        checks++; if (trap_valid !== 1'b1) begin failures++; $display("FAIL illegal_trap_valid got=%0h exp=1", trap_valid); end
        checks++; if (trap_tval !== 32'h800) begin failures++; $display("FAIL illegal_trap_tval got=%0h exp=800", trap_tval); end
        checks++; if (out_taken !== 1'b0) begin failures++; $display("FAIL illegal_out_taken got=%0h exp=0", out_taken); end
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL illegal_redirect got=%0h exp=0", redirect_valid); end
        idle(4);
    endtask

    task automatic test_reset_in_squash;
        out_ready = 1'b0;
        drive(OP_JAL, F3_BEQ, 32'h900, 32'h100, 32'h0, 32'h0, 1'b0);
        tick();
        checks++; if (redirect_pc !== 32'hA00) begin failures++; $display("FAIL rsq_redirect_pc got=%0h exp=a00", redirect_pc); end
        idle(1);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rsq_out_valid got=%0h exp=0", out_valid); end
        checks++; if (out_link !== 32'h0) begin failures++; $display("FAIL rsq_out_link got=%0h exp=0", out_link); end
        checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL rsq_redirect_pc_clr got=%0h exp=0", redirect_pc); end
        checks++; if (out_taken !== 1'b0) begin failures++; $display("FAIL rsq_out_taken got=%0h exp=0", out_taken); end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(OP_BR, F3_BNE, 32'hB00, 32'h8, 32'h1, 32'h2, 1'b1);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rsq_in_ready got=%0h exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rsq_accept got=%0h exp=1", out_valid); end
        checks++; if (out_link !== 32'hB04) begin failures++; $display("FAIL rsq_link got=%0h exp=b04", out_link); end
        checks++; if (redirect_pc !== 32'hB08) begin failures++; $display("FAIL rsq_target got=%0h exp=b08", redirect_pc); end
        idle(4);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_imm    = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_op     = OP_NONE;
        cmp_less  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_blt_taken();
        test_bltu_not_taken();
        test_jalr_misaligned();
        test_beq_stall();
        test_illegal_funct3();
        test_reset_in_squash();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
